// File: rtl/midi_msg_parser.sv
// MIDI channel-voice message parser: assembles {status, data1, data2} words from
// a UART byte stream, with running status, real-time passthrough and channel filter.
module midi_msg_parser #(
  parameter bit         FILTER_EN = 1'b0,
  parameter logic [3:0] FILTER_CH = 4'd0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [7:0]            RX_DAT,
  input  logic                  RX_RDY,
  output logic [23:0]           MIDI_MSG,
  output logic                  MIDI_MSG_RDY,
  output logic                  PARSE_ERR,
  output logic                  RUN_STATUS_VLD
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned MSG_W  = 3 * BYTE_W;

  localparam logic [BYTE_W-1:0] RT_MIN  = 8'hF8;
  localparam logic [BYTE_W-1:0] SYS_MIN = 8'hF0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_D1 = 2'd1,
    WAIT_D2 = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [BYTE_W-1:0]   status_q, status_d;
  logic [BYTE_W-1:0]   data1_q, data1_d;
  logic [BYTE_W-1:0]   data2_q, data2_d;
  logic                emit_c;
  logic                err_c;
  logic                two_byte_c;
  logic                pass_c;

  // Program change (0xC_) and channel pressure (0xD_) carry a single data byte
  assign two_byte_c = (status_q[7:4] == 4'hC) || (status_q[7:4] == 4'hD);
  assign pass_c     = !FILTER_EN || (status_q[3:0] == FILTER_CH);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      status_q <= '0;
      data1_q  <= '0;
      data2_q  <= '0;
    end else begin
      state_q  <= state_d;
      status_q <= status_d;
      data1_q  <= data1_d;
      data2_q  <= data2_d;
    end
  end

  // Byte classification and message assembly
  always_comb begin
    state_d  = state_q;
    status_d = status_q;
    data1_d  = data1_q;
    data2_d  = data2_q;
    emit_c   = 1'b0;
    err_c    = 1'b0;
    if (RX_RDY) begin
      if (RX_DAT >= RT_MIN) begin
        // real-time bytes leave the parse untouched
        state_d = state_q;
      end else if (RX_DAT >= SYS_MIN) begin
        state_d  = IDLE;
        status_d = '0;
      end else if (RX_DAT[7]) begin
        err_c    = (state_q == WAIT_D2);
        status_d = RX_DAT;
        state_d  = WAIT_D1;
      end else begin
        unique case (state_q)
          IDLE: begin
            err_c = 1'b1;
          end
          WAIT_D1: begin
            data1_d = RX_DAT;
            if (two_byte_c) begin
              data2_d = '0;
              emit_c  = 1'b1;
            end else begin
              state_d = WAIT_D2;
            end
          end
          WAIT_D2: begin
            data2_d = RX_DAT;
            emit_c  = 1'b1;
            state_d = WAIT_D1;
          end
          default: begin
            state_d = IDLE;
          end
        endcase
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      MIDI_MSG       <= '0;
      MIDI_MSG_RDY   <= 1'b0;
      PARSE_ERR      <= 1'b0;
      RUN_STATUS_VLD <= 1'b0;
    end else begin
      MIDI_MSG_RDY   <= emit_c && pass_c;
      PARSE_ERR      <= err_c;
      RUN_STATUS_VLD <= (state_d != IDLE);
      if (emit_c && pass_c) begin
        MIDI_MSG <= MSG_W'({status_q, data1_d, data2_d});
      end
    end
  end

endmodule

// File: tb/tb_midi_msg_parser.sv
// Scoreboard bench for midi_msg_parser: an unfiltered and a channel-0-filtered
// instance share one byte stream and are checked against a message-level model.
module tb_midi_msg_parser;

  logic        CLK;
  logic        RST;
  logic [7:0]  RX_DAT;
  logic        RX_RDY;
  logic [23:0] msg0, msg1;
  logic        rdy0, rdy1, err0, err1, rsv0, rsv1;

  midi_msg_parser #(.FILTER_EN(1'b0), .FILTER_CH(4'd0)) dut0 (
    .CLK(CLK), .RST(RST), .RX_DAT(RX_DAT), .RX_RDY(RX_RDY),
    .MIDI_MSG(msg0), .MIDI_MSG_RDY(rdy0), .PARSE_ERR(err0), .RUN_STATUS_VLD(rsv0)
  );

  midi_msg_parser #(.FILTER_EN(1'b1), .FILTER_CH(4'd0)) dut1 (
    .CLK(CLK), .RST(RST), .RX_DAT(RX_DAT), .RX_RDY(RX_RDY),
    .MIDI_MSG(msg1), .MIDI_MSG_RDY(rdy1), .PARSE_ERR(err1), .RUN_STATUS_VLD(rsv1)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic        is_err;
    logic [23:0] msg;
  } ev_t;

  ev_t         exp_q0[$];
  ev_t         exp_q1[$];
  logic [7:0]  pend[$];
  logic        have_st;
  logic [7:0]  st;
  logic        rsv_next, rsv_exp;
  logic [23:0] last0, last1;
  int          checks;
  int          failures;

  // Reference model: reacts to each accepted byte at message level
  task automatic model_byte(input logic [7:0] b);
    int   need;
    ev_t  ev;
    if (b >= 8'hF8) begin
      need = 0;
    end else if (b >= 8'hF0) begin
      have_st = 1'b0;
      pend.delete();
    end else if (b[7]) begin
      if (have_st && pend.size() > 0) begin
        ev = '{is_err: 1'b1, msg: 24'h0};
        exp_q0.push_back(ev);
        exp_q1.push_back(ev);
      end
      have_st = 1'b1;
      st      = b;
      pend.delete();
    end else if (!have_st) begin
      ev = '{is_err: 1'b1, msg: 24'h0};
      exp_q0.push_back(ev);
      exp_q1.push_back(ev);
    end else begin
      pend.push_back(b);
      need = (st[7:4] == 4'hC || st[7:4] == 4'hD) ? 1 : 2;
      if (pend.size() == need) begin
        ev.is_err = 1'b0;
        if (need == 2) ev.msg = {st, pend[0], pend[1]};
        else           ev.msg = {st, pend[0], 8'h00};
        exp_q0.push_back(ev);
        if (st[3:0] == 4'd0) exp_q1.push_back(ev);
        pend.delete();
      end
    end
    rsv_next = have_st;
  endtask

  always @(posedge CLK) rsv_exp = RST ? 1'b0 : rsv_next;

  task automatic send(input logic [7:0] b);
    @(posedge CLK);
    #1;
    RX_DAT = b;
    RX_RDY = 1'b1;
    model_byte(b);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
      RX_RDY = 1'b0;
      RX_DAT = 8'($urandom);
    end
  endtask

  task automatic do_reset();
    idle(2);
    RST      = 1'b1;
    have_st  = 1'b0;
    pend.delete();
    rsv_next = 1'b0;
    rsv_exp  = 1'b0;
    last0    = 24'h0;
    last1    = 24'h0;
    @(negedge CLK);
    checks++;
    if ({msg0, rdy0, err0, rsv0} != 27'h0 || {msg1, rdy1, err1, rsv1} != 27'h0) begin
      failures++;
      $display("FAIL reset_state: dut0=%h/%b%b%b dut1=%h/%b%b%b required all zero",
               msg0, rdy0, err0, rsv0, msg1, rdy1, err1, rsv1);
    end
    @(posedge CLK);
    #1;
    RST = 1'b0;
  endtask

  task automatic check_dut(input int idx, input logic rdy, input logic err,
                           input logic [23:0] msg, input logic rsv);
    ev_t         ev;
    logic        empty;
    logic [23:0] last;
    last = (idx == 0) ? last0 : last1;
    checks++;
    if (rdy && err) begin
      failures++;
      $display("FAIL dut%0d_rdy_err_overlap: rdy=1 err=1 required not both", idx);
    end else if (rdy || err) begin
      empty = (idx == 0) ? (exp_q0.size() == 0) : (exp_q1.size() == 0);
      if (empty) begin
        failures++;
        $display("FAIL dut%0d_unexpected: rdy=%b err=%b msg=%h required no event", idx, rdy, err, msg);
      end else begin
        ev = (idx == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
        if (ev.is_err != err || (!ev.is_err && ev.msg != msg)) begin
          failures++;
          $display("FAIL dut%0d_event: got err=%b msg=%h required err=%b msg=%h",
                   idx, err, msg, ev.is_err, ev.msg);
        end
        if (!ev.is_err) begin
          if (idx == 0) last0 = ev.msg;
          else          last1 = ev.msg;
        end
      end
    end else if (msg != last) begin
      failures++;
      $display("FAIL dut%0d_msg_hold: got %h required %h", idx, msg, last);
    end
    checks++;
    if (rsv != rsv_exp) begin
      failures++;
      $display("FAIL dut%0d_run_status_vld: got %b required %b", idx, rsv, rsv_exp);
    end
  endtask

  // Monitor: consumes expected events whenever a DUT presents one
  always @(negedge CLK) begin
    if (!RST) begin
      check_dut(0, rdy0, err0, msg0, rsv0);
      check_dut(1, rdy1, err1, msg1, rsv1);
    end
  end

  function automatic logic [7:0] rand_byte();
    int unsigned r;
    r = $urandom_range(0, 99);
    if (r < 55)      return 8'($urandom_range(0, 127));
    else if (r < 80) return {4'($urandom_range(8, 14)), ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom)};
    else if (r < 90) return 8'($urandom_range(248, 255));
    else             return 8'($urandom_range(240, 247));
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks   = 0;
    failures = 0;
    RST      = 1'b1;
    RX_RDY   = 1'b0;
    RX_DAT   = 8'h00;
    have_st  = 1'b0;
    st       = 8'h00;
    rsv_next = 1'b0;
    rsv_exp  = 1'b0;
    last0    = 24'h0;
    last1    = 24'h0;
    do_reset();

    // data with no status, then truncated note-on followed by a new status
    send(8'h3C); idle(1);
    send(8'h90); send(8'h3C); send(8'h64); idle(2);
    send(8'h40); send(8'h00); idle(1);
    send(8'h80); send(8'h3C); send(8'hF8); send(8'h00); idle(1);
    send(8'hC5); send(8'h07); send(8'h09); idle(1);
    send(8'h90); send(8'h3C); send(8'hB0); send(8'h7B); send(8'h00); idle(1);
    send(8'h91); send(8'h3C); send(8'h64); idle(1);
    send(8'hD0); send(8'h11); send(8'hFE); send(8'h22); idle(1);
    send(8'hF0); send(8'h3C); idle(2);
    send(8'h90); send(8'h3C);
    do_reset();
    send(8'h64); idle(2);

    for (int n = 0; n < 3000; n++) begin
      send(rand_byte());
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      if ($urandom_range(0, 499) == 0) do_reset();
    end
    idle(4);

    checks++;
    if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
      failures++;
      $display("FAIL missing_events: pending dut0=%0d dut1=%0d required 0",
               exp_q0.size(), exp_q1.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
